// File: rtl/dpram_asym.sv
// Single-clock asymmetric dual-port RAM: wide byte-enabled port A, narrow lane port B,
// with a defined collision policy, optional output register and post-reset zero-fill.
module dpram_asym #(
  parameter int unsigned AW_B           = 9,
  parameter int unsigned DW_B           = 16,
  parameter int unsigned RATIO          = 2,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned WRITE_FIRST    = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned DW_A = DW_B * RATIO,
  localparam int unsigned LW   = $clog2(RATIO),
  localparam int unsigned AW_A = AW_B - LW,
  localparam int unsigned NB   = DW_A / 8
) (
  input  logic            clk,
  input  logic            reset,
  output logic            busy,
  input  logic            cea,
  input  logic            wrea,
  input  logic [NB-1:0]   bea,
  input  logic [AW_A-1:0] ada,
  input  logic [DW_A-1:0] dina,
  output logic [DW_A-1:0] douta,
  output logic            valida,
  input  logic            ceb,
  input  logic            wreb,
  input  logic [AW_B-1:0] adb,
  input  logic [DW_B-1:0] dinb,
  output logic [DW_B-1:0] doutb,
  output logic            validb
);

  localparam int unsigned LWB     = (LW == 0) ? 1 : LW;
  localparam int unsigned DEPTH_A = 1 << AW_A;
  localparam logic [0:0]  ST_CLEAR = 1'b0;
  localparam logic [0:0]  ST_READY = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [AW_A-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  // Zero-fill sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_CLEAR: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + AW_A'(1);
        if (cnt_q == '1) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_READY: busy_d = 1'b0;
      default: begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;

  logic            clr;
  logic            acc_a, wr_a, acc_b, wr_b;
  logic [AW_A-1:0] wb_addr;
  logic [LWB-1:0]  lane_b;
  int unsigned     lane_off;

  assign clr      = (state_q == ST_CLEAR);
  assign acc_a    = cea & ~busy_q;
  assign wr_a     = acc_a & wrea;
  assign acc_b    = ceb & ~busy_q;
  assign wr_b     = acc_b & wreb;
  assign wb_addr  = AW_A'(adb >> LW);
  assign lane_b   = (RATIO == 1) ? '0 : LWB'(adb);
  assign lane_off = 32'(lane_b) * DW_B;

  logic [DW_A-1:0] mem [DEPTH_A];
  logic [DW_A-1:0] old_a, new_a, old_b, new_b, rd_a_c, rd_b_wide_c;
  logic [DW_B-1:0] rd_b_c;

  // Post-collision word at each port's address: B lane first, then A bytes override
  always_comb begin
    old_a = mem[ada];
    new_a = old_a;
    if (wr_b && (wb_addr == ada)) new_a[lane_off +: DW_B] = dinb;
    for (int i = 0; i < NB; i++) begin
      if (wr_a && bea[i]) new_a[8*i +: 8] = dina[8*i +: 8];
    end
    old_b = mem[wb_addr];
    new_b = old_b;
    if (wr_b) new_b[lane_off +: DW_B] = dinb;
    for (int i = 0; i < NB; i++) begin
      if (wr_a && (ada == wb_addr) && bea[i]) new_b[8*i +: 8] = dina[8*i +: 8];
    end
  end

  assign rd_a_c      = (WRITE_FIRST != 0) ? new_a : old_a;
  assign rd_b_wide_c = (WRITE_FIRST != 0) ? new_b : old_b;
  assign rd_b_c      = rd_b_wide_c[lane_off +: DW_B];

  // Both ports write the same merged word on a collision, so order is irrelevant
  always_ff @(posedge clk) begin
    if (clr) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr_a) mem[ada] <= new_a;
      if (wr_b) mem[wb_addr] <= new_b;
    end
  end

  logic [DW_A-1:0] douta1_q, douta2_q;
  logic [DW_B-1:0] doutb1_q, doutb2_q;
  logic            valida1_q, valida2_q, validb1_q, validb2_q;

  // Read pipeline; data registers hold when no read completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      douta1_q  <= '0;
      douta2_q  <= '0;
      doutb1_q  <= '0;
      doutb2_q  <= '0;
      valida1_q <= 1'b0;
      valida2_q <= 1'b0;
      validb1_q <= 1'b0;
      validb2_q <= 1'b0;
    end else begin
      valida1_q <= acc_a;
      validb1_q <= acc_b;
      valida2_q <= valida1_q;
      validb2_q <= validb1_q;
      if (acc_a) douta1_q <= rd_a_c;
      if (acc_b) doutb1_q <= rd_b_c;
      if (valida1_q) douta2_q <= douta1_q;
      if (validb1_q) doutb2_q <= doutb1_q;
    end
  end

  assign douta  = (OUT_REG != 0) ? douta2_q  : douta1_q;
  assign valida = (OUT_REG != 0) ? valida2_q : valida1_q;
  assign doutb  = (OUT_REG != 0) ? doutb2_q  : doutb1_q;
  assign validb = (OUT_REG != 0) ? validb2_q : validb1_q;

endmodule

// File: tb/tb_dpram_asym.sv
// Directed bench for dpram_asym: three instances (default, write-first, output register)
// share one stimulus stream and are checked against hand-computed values.
module tb_dpram_asym;

  logic        clk = 1'b0;
  logic        reset;
  logic        cea, wrea, ceb, wreb;
  logic [3:0]  bea;
  logic [7:0]  ada;
  logic [31:0] dina;
  logic [8:0]  adb;
  logic [15:0] dinb;

  logic        busy0, busy1, busy2;
  logic [31:0] douta0, douta1, douta2;
  logic [15:0] doutb0, doutb1, doutb2;
  logic        valida0, valida1, valida2, validb0, validb1, validb2;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dpram_asym u_dut0 (
    .clk(clk), .reset(reset), .busy(busy0),
    .cea(cea), .wrea(wrea), .bea(bea), .ada(ada), .dina(dina), .douta(douta0), .valida(valida0),
    .ceb(ceb), .wreb(wreb), .adb(adb), .dinb(dinb), .doutb(doutb0), .validb(validb0)
  );

  dpram_asym #(.WRITE_FIRST(1)) u_dut1 (
    .clk(clk), .reset(reset), .busy(busy1),
    .cea(cea), .wrea(wrea), .bea(bea), .ada(ada), .dina(dina), .douta(douta1), .valida(valida1),
    .ceb(ceb), .wreb(wreb), .adb(adb), .dinb(dinb), .doutb(doutb1), .validb(validb1)
  );

  dpram_asym #(.OUT_REG(1)) u_dut2 (
    .clk(clk), .reset(reset), .busy(busy2),
    .cea(cea), .wrea(wrea), .bea(bea), .ada(ada), .dina(dina), .douta(douta2), .valida(valida2),
    .ceb(ceb), .wreb(wreb), .adb(adb), .dinb(dinb), .doutb(doutb2), .validb(validb2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cea = 0; wrea = 0; bea = 4'h0; ada = 8'h00; dina = 32'h0;
    ceb = 0; wreb = 0; adb = 9'h000; dinb = 16'h0;
  endtask

  task automatic port_a(input logic we, input logic [3:0] be, input logic [7:0] a, input logic [31:0] d);
    cea = 1; wrea = we; bea = be; ada = a; dina = d;
  endtask

  task automatic port_b(input logic we, input logic [8:0] a, input logic [15:0] d);
    ceb = 1; wreb = we; adb = a; dinb = d;
  endtask

  int n_busy;
  int n_vld;

  initial begin
    idle();
    reset = 1;
    tick();
    tick();
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_douta", douta0, 32'h0);
    chk("rst_doutb", 32'(doutb0), 32'h0);
    chk("rst_valida", 32'(valida0), 32'd0);
    chk("rst_validb", 32'(validb2), 32'd0);

    // Initial sweep length
    reset = 0;
    n_busy = 0;
    do begin
      tick();
      n_busy++;
    end while (busy0 && n_busy < 1000);
    chk("sweep_len", 32'(n_busy), 32'd256);
    chk("sweep_busy_oreg", 32'(busy2), 32'd0);

    // Zero-filled array, one-cycle read latency
    for (int i = 0; i < 256; i++) begin
      port_a(0, 4'h0, 8'(i), 32'h0);
      tick();
      if (valida0 !== 1'b1 || douta0 !== 32'h0) chk("zero_read", {valida0, douta0[30:0]}, 32'h8000_0000);
      else chk("zero_read", douta0, 32'h0);
    end
    idle();
    tick();
    chk("idle_valida", 32'(valida0), 32'd0);

    // Full-word A write, read back per lane on B
    port_a(1, 4'hF, 8'h12, 32'hDEAD_BEEF);
    tick();
    chk("wr_rdfirst_a", douta0, 32'h0);
    chk("wr_wrfirst_a", douta1, 32'hDEAD_BEEF);
    idle();
    port_b(0, 9'h024, 16'h0);
    tick();
    chk("b_lane0", 32'(doutb0), 32'h0000_BEEF);
    chk("b_lane0_vld", 32'(validb0), 32'd1);
    chk("a_no_vld", 32'(valida0), 32'd0);
    port_b(0, 9'h025, 16'h0);
    tick();
    chk("b_lane1", 32'(doutb0), 32'h0000_DEAD);

    // B lane write lands in the upper half of the wide word
    idle();
    port_b(1, 9'h031, 16'h1234);
    tick();
    idle();
    port_a(0, 4'h0, 8'h18, 32'h0);
    tick();
    chk("b_to_a", douta0, 32'h1234_0000);

    // Collision on lane 0: A bytes win
    idle();
    port_a(1, 4'h3, 8'h20, 32'hAAAA_5555);
    port_b(1, 9'h040, 16'hCCCC);
    tick();
    chk("col0_wf_a", douta1, 32'h0000_5555);
    chk("col0_wf_b", 32'(doutb1), 32'h0000_5555);
    chk("col0_rf_a", douta0, 32'h0);
    idle();
    port_a(0, 4'h0, 8'h20, 32'h0);
    tick();
    chk("col0_word", douta0, 32'h0000_5555);

    // Collision on lane 1: both writes land
    idle();
    port_a(1, 4'h3, 8'h20, 32'hAAAA_5555);
    port_b(1, 9'h041, 16'hCCCC);
    tick();
    chk("col1_wf_a", douta1, 32'hCCCC_5555);
    chk("col1_wf_b", 32'(doutb1), 32'h0000_CCCC);
    chk("col1_rf_a", douta0, 32'h0000_5555);
    chk("col1_rf_b", 32'(doutb0), 32'h0);
    idle();
    port_a(0, 4'h0, 8'h20, 32'h0);
    tick();
    chk("col1_word", douta0, 32'hCCCC_5555);

    // Cross-port read during write, and the output-register latency
    idle();
    port_a(1, 4'hF, 8'h30, 32'h1111_1111);
    tick();
    idle();
    port_a(1, 4'hF, 8'h30, 32'h2222_2222);
    port_b(0, 9'h060, 16'h0);
    tick();
    chk("rdw_rf_b", 32'(doutb0), 32'h0000_1111);
    chk("rdw_wf_b", 32'(doutb1), 32'h0000_2222);
    chk("rdw_oreg_nvld", 32'(validb2), 32'd0);
    idle();
    tick();
    chk("rdw_oreg_vldb", 32'(validb2), 32'd1);
    chk("rdw_oreg_b", 32'(doutb2), 32'h0000_1111);
    chk("rdw_oreg_a", douta2, 32'h1111_1111);
    chk("hold_vldb", 32'(validb0), 32'd0);
    chk("hold_b", 32'(doutb0), 32'h0000_1111);
    port_b(0, 9'h060, 16'h0);
    tick();
    idle();
    chk("next_cyc_b", 32'(doutb0), 32'h0000_2222);

    // Reset mid-sweep restarts the fill; requests during busy are ignored
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_busy", 32'(busy0), 32'd1);
    port_a(1, 4'hF, 8'h12, 32'hFFFF_FFFF);
    port_b(1, 9'h025, 16'hFFFF);
    reset = 1;
    tick();
    chk("mid_rst_busy", 32'(busy0), 32'd1);
    reset = 0;
    n_busy = 0;
    n_vld = 0;
    do begin
      tick();
      n_busy++;
      if (valida0 || validb0) n_vld++;
    end while (busy0 && n_busy < 1000);
    idle();
    chk("restart_len", 32'(n_busy), 32'd256);
    chk("busy_no_vld", 32'(n_vld), 32'd0);
    port_a(0, 4'h0, 8'h12, 32'h0);
    port_b(0, 9'h024, 16'h0);
    tick();
    chk("busy_no_wr_a", douta0, 32'h0);
    chk("busy_no_wr_b", 32'(doutb0), 32'h0);
    chk("post_vld_a", 32'(valida0), 32'd1);
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
